// File: rtl/jtag_scan_sequencer_if.sv
// Command/response bundle between a scan host and jtag_scan_sequencer.
// JTAG_SCAN_SEQ_TLR_CMD_EN adds the cmd_tlr request bit.
interface jtag_scan_sequencer_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_ir;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
`ifdef JTAG_SCAN_SEQ_TLR_CMD_EN
    logic               cmd_tlr;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;

`ifdef JTAG_SCAN_SEQ_TLR_CMD_EN
    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data, cmd_tlr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data, cmd_tlr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
`else
    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
`endif
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Walks the TAP graph for one IR/DR scan per command, LSB-first shift.
// JTAG_SCAN_SEQ_TLR_CMD_EN enables test-logic-reset commands.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                  tck_i,
    input  logic                  rst_ni,
    jtag_scan_sequencer_if.slave  bus,
    output logic                  tms_o,
    output logic                  tdi_o,
    input  logic                  tdo_i
);
    typedef enum logic [3:0] {
        TLR_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE,
        SHIFT, EXIT1, UPDATE, RSP
    } state_t;

    state_t             state;
    logic [2:0]         tlr_cnt;
    logic               tlr_cmd_q;
    logic               ir_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               tlr_req;
    logic               len_bad;

`ifdef JTAG_SCAN_SEQ_TLR_CMD_EN
    assign tlr_req = bus.cmd_tlr;
`else
    assign tlr_req = 1'b0;
`endif

    assign len_bad = (bus.cmd_len == '0) ||
                     (bus.cmd_len > LEN_W'(MAX_LEN));

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= TLR_SEQ;
            tlr_cnt     <= '0;
            tlr_cmd_q   <= 1'b0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
        end else begin
            unique case (state)
                // Five edges see tms=1, the sixth sees tms=0 (Run-Test/Idle).
                TLR_SEQ: begin
                    tlr_cnt <= tlr_cnt + 3'd1;
                    if (tlr_cnt == 3'd4) tms_o <= 1'b0;
                    if (tlr_cnt == 3'd5) begin
                        tlr_cnt <= '0;
                        tms_o   <= 1'b0;
                        if (tlr_cmd_q) begin
                            tlr_cmd_q   <= 1'b0;
                            state       <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_data_q  <= '0;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    tms_o <= 1'b0;
                    if (bus.cmd_valid) begin
                        ready_q <= 1'b0;
                        ir_q    <= bus.cmd_ir;
                        len_q   <= bus.cmd_len;
                        data_q  <= bus.cmd_data;
                        cap_q   <= '0;
                        cnt     <= '0;
                        if (tlr_req) begin
                            state     <= TLR_SEQ;
                            tlr_cnt   <= '0;
                            tlr_cmd_q <= 1'b1;
                            tms_o     <= 1'b1;
                        end else if (len_bad) begin
                            state       <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state <= SEL_DR;
                            tms_o <= 1'b1;
                        end
                    end
                end
                SEL_DR: begin
                    tms_o <= ir_q;
                    state <= ir_q ? SEL_IR : CAPTURE;
                end
                SEL_IR: begin
                    tms_o <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    tms_o <= 1'b0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                // cnt==0 is the Capture->Shift cycle; cnt==k+1 presents bit k.
                SHIFT: begin
                    if (cnt != '0)
                        cap_q <= cap_q | (MAX_LEN'(tdo_i) << (cnt - 1'b1));
                    if (cnt == len_q) begin
                        tms_o <= 1'b1;
                        tdi_o <= 1'b0;
                        state <= EXIT1;
                    end else begin
                        tdi_o  <= data_q[0];
                        data_q <= data_q >> 1;
                        tms_o  <= (cnt == len_q - 1'b1);
                        cnt    <= cnt + 1'b1;
                    end
                end
                EXIT1: begin
                    tms_o <= 1'b0;
                    state <= UPDATE;
                end
                UPDATE: begin
                    tms_o       <= 1'b0;
                    state       <= RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= cap_q;
                end
                RSP: begin
                    tms_o <= 1'b0;
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= TLR_SEQ;
            endcase
        end
    end
endmodule
